uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
//   Full-duplex UART with parametrised clock/baud, data width, parity and stop bits.
//   TX: valid/ready byte interface. RX: 16x oversampled with mid-bit sampling.
//   Replaces fixed 8N1 TX-only serial logic; sits between board pins and the
//   command/console logic, all in the single system clock domain.
// PARAMETERS
//   CLOCK_HZ   12_000_000  system clock frequency
//   BAUD_HZ    9_600       line rate; DIV = CLOCK_HZ/(BAUD_HZ*16), integer-truncated, must be >=2
//   DATA_BITS  8           data bits per frame, legal 5..8
//   PARITY     0           0 none, 1 odd, 2 even
//   STOP_BITS  1           TX stop bits, 1 or 2 (RX checks first stop bit only)
// PORTS
//   clock          in   1          system clock
//   reset          in   1          asynchronous, active-high
//   tx_data        in   DATA_BITS  byte to send, captured on accept
//   tx_valid       in   1          tx_data valid
//   tx_ready       out  1          TX idle, can accept
//   serial_tx      out  1          line out, idle high
//   serial_rx      in   1          line in, asynchronous
//   rx_data        out  DATA_BITS  last received word
//   rx_valid       out  1          one-cycle pulse, rx_data/errors updated
//   rx_parity_err  out  1          parity mismatch on last word (0 if PARITY=0)
//   rx_frame_err   out  1          stop bit sampled low on last word
// BEHAVIOUR
//   Reset (async): serial_tx=1, tx_ready=1, rx_valid=0, rx_data=0, both errs=0,
//     tick divider=0, both FSMs IDLE, rx synchroniser flops=1. Partial frames dropped.
//   Tick: free-running counter 0..DIV-1; tick pulses 1 cycle when count==DIV-1.
//   Bit time = 16 ticks. Order: start(0), data LSB first, [parity], stop(1)x STOP_BITS.
//   Parity bit = ^data for even, ~^data for odd.
//   TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE:
//     - accept when tx_valid&&tx_ready (IDLE only); tx_data latched, tx_ready=0 next cycle,
//       serial_tx=0 from next cycle; tx_data changes after accept are ignored.
//     - start bit ends on its 16th tick (first bit may be shorter by <1 tick).
//     - DATA shifts one bit per 16 ticks, DATA_BITS bits; STOP lasts STOP_BITS*16 ticks.
//     - end of STOP: IDLE, tx_ready=1 same cycle; back-to-back words possible when
//       tx_valid is held (>=1 cycle idle high between frames).
//     - serial_tx is a registered output (glitch-free).
//   RX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE (plus WAIT_HIGH):
//     - serial_rx through 2-flop synchroniser; all decisions use synced value on ticks.
//     - IDLE: synced low on a tick -> START, phase counter=0.
//     - START: at phase 7 (mid-bit) sample; high -> false start, back to IDLE, no rx_valid.
//     - DATA/PARITY: sample each bit at phase 7 relative to its start, 16 ticks apart.
//     - STOP: sample at mid-bit; cycle after sample rx_valid=1 for exactly 1 cycle,
//       rx_data, rx_parity_err, rx_frame_err updated together and held until next rx_valid.
//     - stop sample high -> IDLE; low (framing error/break) -> WAIT_HIGH, re-arm
//       only after a tick with synced line high.
//     - no RX backpressure: a new word simply overwrites rx_data.
//   TX and RX independent; simultaneous TX accept and RX completion both proceed.
//   Reset asserted mid-frame: serial_tx high immediately, no rx_valid for the partial frame.
// TESTING (bench uses CLOCK_HZ=64*BAUD_HZ -> DIV=4, bit = 64 clocks)
//   1. 8N1, send 0x41 -> serial_tx: 0,1,0,0,0,0,0,1,0,1 each 64 clk (+-4); tx_ready low throughout.
//   2. Loopback tx->rx, PARITY=2, words 0x00,0xFF,0xA5 held valid back-to-back -> 3 rx_valid
//      pulses, rx_data matches, parity_err=0, >=1 idle cycle between frames.
//   3. PARITY=1, inject 0x55 with wrong parity bit -> rx_valid, rx_data=0x55, parity_err=1.
//   4. Drive 16-clock low glitch on serial_rx -> false start, no rx_valid, next good 0x3C received.
//   5. Hold serial_rx low 20 bit times -> one rx_valid, rx_data=0x00, frame_err=1; no more words
//      until line high; following 0x81 received with frame_err=0.
//   6. Assert reset mid-TX-data and mid-RX-data -> serial_tx=1, tx_ready=1 immediately,
//      no rx_valid; after release, 0x12 transmits and receives correctly.

Source files
------------

// File: rtl/uart_core.sv
// Full-duplex UART: shared 16x tick divider, valid/ready transmitter and an
// oversampling receiver that samples each bit at its middle.
module uart_core #(
    parameter int CLOCK_HZ  = 12_000_000,
    parameter int BAUD_HZ   = 9_600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_tx,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int DIV = CLOCK_HZ / (BAUD_HZ * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(DIV - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * 16 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Handshake: a word is accepted on any clock edge where tx_valid && tx_ready;
    // tx_ready is high exactly while the transmitter is idle.
    tx_state_t              tx_state, tx_next;
    logic [4:0]             tx_phase;
    logic [2:0]             tx_bit_cnt;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   tx_bit_end;

    assign tx_ready   = (tx_state == TX_IDLE);
    assign tx_bit_end = tick && (tx_phase[3:0] == 4'hF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit_cnt == DATA_LAST)
                           tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tick && tx_phase == STOP_LAST) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_phase   <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            serial_tx  <= 1'b1;
        end else begin
            if (tx_state != tx_next) tx_phase <= '0;
            else if (tick)           tx_phase <= tx_phase + 5'd1;
            case (tx_state)
                TX_IDLE: if (tx_valid) begin
                    tx_shift   <= tx_data;
                    tx_par     <= parity_of(tx_data);
                    tx_bit_cnt <= '0;
                    serial_tx  <= 1'b0;
                end
                TX_START: if (tx_bit_end) begin
                    serial_tx <= tx_shift[0];
                    tx_shift  <= tx_shift >> 1;
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bit_cnt == DATA_LAST) begin
                        serial_tx <= (PARITY != 0) ? tx_par : 1'b1;
                    end else begin
                        serial_tx  <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_cnt <= tx_bit_cnt + 3'd1;
                    end
                end
                TX_PARITY: if (tx_bit_end) serial_tx <= 1'b1;
                default: ;
            endcase
        end
    end

    rx_state_t              rx_state, rx_next;
    logic                   rx_meta, rx_sync;
    logic [3:0]             rx_phase;
    logic [2:0]             rx_bit_cnt;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par_bit;
    logic                   rx_sample;

    // Start is checked 8 ticks after detection; every later bit 16 ticks after that.
    assign rx_sample = tick && ((rx_state == RX_START) ? (rx_phase == 4'd7)
                                                       : (rx_phase == 4'd15));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (tick && !rx_sync) rx_next = RX_START;
            RX_START:     if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_sample && rx_bit_cnt == DATA_LAST)
                              rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_sample) rx_next = RX_STOP;
            RX_STOP:      if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (tick && rx_sync) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_phase      <= '0;
            rx_bit_cnt    <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_meta  <= serial_rx;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            if (rx_state != rx_next) rx_phase <= '0;
            else if (tick)           rx_phase <= rx_phase + 4'd1;
            if (rx_sample) begin
                case (rx_state)
                    RX_START: rx_bit_cnt <= '0;
                    RX_DATA: begin
                        rx_shift   <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        rx_bit_cnt <= rx_bit_cnt + 3'd1;
                    end
                    RX_PARITY: rx_par_bit <= rx_sync;
                    RX_STOP: begin
                        rx_valid      <= 1'b1;
                        rx_data       <= rx_shift;
                        rx_frame_err  <= ~rx_sync;
                        rx_parity_err <= (PARITY != 0) && (rx_par_bit != parity_of(rx_shift));
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (8N1, 8E1 loopback, 8O1)
// at 64 clocks per bit.
module tb_uart_core;

    localparam int BAUD = 9_600;
    localparam int CLK  = 64 * BAUD;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // instance A: 8N1, rx from bench or looped back from its own tx
    logic [7:0] tx_data_a = '0;
    logic       tx_valid_a = 1'b0;
    logic       tx_ready_a, serial_tx_a;
    logic       drv_a = 1'b1;
    logic       loop_a = 1'b0;
    logic       rx_line_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a, rx_perr_a, rx_ferr_a;
    assign rx_line_a = loop_a ? serial_tx_a : drv_a;

    // instance B: even parity, permanent loopback
    logic [7:0] tx_data_b = '0;
    logic       tx_valid_b = 1'b0;
    logic       tx_ready_b, serial_tx_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b, rx_perr_b, rx_ferr_b;

    // instance C: odd parity, rx from bench
    logic [7:0] tx_data_c = '0;
    logic       tx_valid_c = 1'b0;
    logic       tx_ready_c, serial_tx_c;
    logic       drv_c = 1'b1;
    logic [7:0] rx_data_c;
    logic       rx_valid_c, rx_perr_c, rx_ferr_c;

    uart_core #(.CLOCK_HZ(CLK), .BAUD_HZ(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clock(clock), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .serial_tx(serial_tx_a), .serial_rx(rx_line_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_parity_err(rx_perr_a),
        .rx_frame_err(rx_ferr_a));

    uart_core #(.CLOCK_HZ(CLK), .BAUD_HZ(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clock(clock), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .serial_tx(serial_tx_b), .serial_rx(serial_tx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_parity_err(rx_perr_b),
        .rx_frame_err(rx_ferr_b));

    uart_core #(.CLOCK_HZ(CLK), .BAUD_HZ(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clock(clock), .reset(reset), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
        .tx_ready(tx_ready_c), .serial_tx(serial_tx_c), .serial_rx(drv_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_parity_err(rx_perr_c),
        .rx_frame_err(rx_ferr_c));

    // received words as {frame_err, parity_err, data}
    logic [9:0] rcv_a_q[$];
    logic [9:0] rcv_b_q[$];
    logic [9:0] rcv_c_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clock) begin
        if (rx_valid_a) rcv_a_q.push_back({rx_ferr_a, rx_perr_a, rx_data_a});
        if (rx_valid_b) rcv_b_q.push_back({rx_ferr_b, rx_perr_b, rx_data_b});
        if (rx_valid_c) rcv_c_q.push_back({rx_ferr_c, rx_perr_c, rx_data_c});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int which);
        if (which == 0) return rcv_a_q.size();
        else if (which == 1) return rcv_b_q.size();
        else return rcv_c_q.size();
    endfunction

    function automatic logic [9:0] qpop(input int which);
        logic [9:0] r;
        r = 10'h3FF;
        if (which == 0 && rcv_a_q.size() > 0) r = rcv_a_q.pop_front();
        if (which == 1 && rcv_b_q.size() > 0) r = rcv_b_q.pop_front();
        if (which == 2 && rcv_c_q.size() > 0) r = rcv_c_q.pop_front();
        return r;
    endfunction

    task automatic wait_count(input int which, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (qsize(which) < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(tag, qsize(which), n);
    endtask

    task automatic check_word(input int which, input string tag, input logic [7:0] d,
                              input logic perr, input logic ferr);
        logic [9:0] r;
        r = qpop(which);
        check({tag, "_data"}, r[7:0], d);
        check({tag, "_perr"}, r[8], perr);
        check({tag, "_ferr"}, r[9], ferr);
    endtask

    task automatic drive_line(input int which, input logic b, input int clks);
        if (which == 0) drv_a = b;
        else drv_c = b;
        repeat (clks) @(negedge clock);
    endtask

    task automatic drive_frame(input int which, input logic [7:0] d, input bit has_par,
                               input logic par);
        drive_line(which, 1'b0, 64);
        for (int i = 0; i < 8; i++) drive_line(which, d[i], 64);
        if (has_par) drive_line(which, par, 64);
        drive_line(which, 1'b1, 64);
        drive_line(which, 1'b1, 64);
    endtask

    task automatic wait_ready_a(input string tag);
        int k;
        k = 0;
        while (!tx_ready_a && k < 1000) begin
            @(negedge clock);
            k++;
        end
        check(tag, tx_ready_a, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] t1_bits;
        logic [7:0] t2_words [3];
        int k;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_tx_line", serial_tx_a, 1'b1);
        check("rst_tx_ready", tx_ready_a, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rx_valid", rx_valid_a, 1'b0);
        check("rst_rx_data", rx_data_a, 8'h00);
        check("rst_perr", rx_perr_a, 1'b0);
        check("rst_ferr", rx_ferr_a, 1'b0);
        check("rst_b_line", serial_tx_b, 1'b1);

        // 1: 8N1 transmit of 0x41, sampled mid-bit
        t1_bits = {1'b1, 8'h41, 1'b0};
        tx_data_a = 8'h41;
        tx_valid_a = 1'b1;
        @(negedge clock);
        tx_valid_a = 1'b0;
        tx_data_a = 8'hFF;
        check("t1_accept_ready", tx_ready_a, 1'b0);
        check("t1_accept_line", serial_tx_a, 1'b0);
        repeat (31) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            check("t1_bit", serial_tx_a, t1_bits[i]);
            check("t1_busy", tx_ready_a, 1'b0);
            if (i < 9) repeat (64) @(negedge clock);
        end
        wait_ready_a("t1_ready_back");
        check("t1_idle_line", serial_tx_a, 1'b1);

        // 2: even-parity loopback, valid held back-to-back
        t2_words[0] = 8'h00;
        t2_words[1] = 8'hFF;
        t2_words[2] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tx_data_b = t2_words[i];
            tx_valid_b = 1'b1;
            exp_q.push_back(t2_words[i]);
            k = 0;
            while (!tx_ready_b && k < 1000) begin
                @(negedge clock);
                k++;
            end
            check("t2_gap_ready", tx_ready_b, 1'b1);
            check("t2_gap_line", serial_tx_b, 1'b1);
            @(negedge clock);
            check("t2_accepted", tx_ready_b, 1'b0);
        end
        tx_valid_b = 1'b0;
        wait_count(1, 3, 2500, "t2_count");
        for (int i = 0; i < 3; i++) begin
            check_word(1, "t2_word", exp_q.pop_front(), 1'b0, 1'b0);
        end

        // 3: odd parity, 0x55 with parity bit 0 (correct would be 1)
        drive_frame(2, 8'h55, 1'b1, 1'b0);
        wait_count(2, 1, 200, "t3_count");
        check_word(2, "t3_word", 8'h55, 1'b1, 1'b0);

        // 4: 16-clock glitch is a false start, then 0x3C
        drive_line(0, 1'b0, 16);
        drive_line(0, 1'b1, 200);
        check("t4_no_valid", qsize(0), 0);
        drive_frame(0, 8'h3C, 1'b0, 1'b0);
        wait_count(0, 1, 200, "t4_count");
        check_word(0, "t4_word", 8'h3C, 1'b0, 1'b0);

        // 5: 20-bit break yields one framing-error word only
        drive_line(0, 1'b0, 20 * 64);
        wait_count(0, 1, 10, "t5_break_count");
        drive_line(0, 1'b1, 128);
        check("t5_after_high", qsize(0), 1);
        check_word(0, "t5_break", 8'h00, 1'b0, 1'b1);
        drive_frame(0, 8'h81, 1'b0, 1'b0);
        wait_count(0, 1, 200, "t5_count");
        check_word(0, "t5_word", 8'h81, 1'b0, 1'b0);

        // 6: reset in the middle of a looped-back frame
        loop_a = 1'b1;
        tx_data_a = 8'h12;
        tx_valid_a = 1'b1;
        @(negedge clock);
        tx_valid_a = 1'b0;
        repeat (3 * 64) @(negedge clock);
        check("t6_mid_line", serial_tx_a, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_rst_line", serial_tx_a, 1'b1);
        check("t6_rst_ready", tx_ready_a, 1'b1);
        check("t6_rst_valid", rx_valid_a, 1'b0);
        check("t6_rst_data", rx_data_a, 8'h00);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (800) @(negedge clock);
        check("t6_no_partial", qsize(0), 0);
        tx_data_a = 8'h12;
        tx_valid_a = 1'b1;
        @(negedge clock);
        tx_valid_a = 1'b0;
        wait_count(0, 1, 900, "t6_count");
        check_word(0, "t6_word", 8'h12, 1'b0, 1'b0);
        wait_ready_a("t6_ready_back");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
